pmod_als_spi_receiver: RTL and testbench

PMOD_ALS_SPI_RECEIVER -- requirements
Module: pmod_als_spi_receiver

---
 rtl/pmod_als_spi_receiver.sv | 174 +++++++++++++++++
 tb/tb_pmod_als_spi_receiver.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_als_spi_receiver.sv
// -----------------------------------------------------------------------------
// pmod_als_spi_receiver
//
// Receives 16-bit frames from a Pmod ALS ambient light sensor over a
// read-only SPI link. The sensor sends its 8-bit light value in frame bits
// [11:4]. The other frame bits are expected to be zero, and a nonzero bit
// there is reported on frame_err.
//
// The serial clock runs all the time, even between frames, because the
// sensor uses the SCK edges it sees while cs is high to reload its shift
// buffer. The sensor drives sdo on SCK falling edges, and this block samples
// sdo on SCK rising edges, MSB first.
//
// Handshake: start is a request strobe that is sampled on every clk.
//   - A start seen in IDLE is accepted at once.
//   - A start seen while busy sets a one-deep pending flag. Any further
//     start that arrives while the flag is set is dropped.
//   - valid is a one-clk pulse. It marks the clk in which value and
//     frame_err take a new result. Both then hold until the next pulse.
//   - There is no ready signal: the consumer must take the result on the
//     cycle that valid is high.
//
// Parameters:
//   DIV        SCK half-period in clk cycles. Legal range is 2..255.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      conversion request
//   sdo        serial data from the sensor
//   cs         chip select, active-low
//   sck        serial clock, free-running
//   busy       low only while the receiver is idle
//   value      last received light value (frame bits [11:4])
//   valid      one-clk pulse when value/frame_err update
//   frame_err  frame bits [15:12] or [3:0] were nonzero in the last frame
//   fsm_state  current FSM state, for observation
// -----------------------------------------------------------------------------
module pmod_als_spi_receiver #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sdo,
    output logic       cs,
    output logic       sck,
    output logic       busy,
    output logic [7:0] value,
    output logic       valid,
    output logic       frame_err,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_SHIFT = 3'd2,
        S_DONE  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  bitcnt;
    logic [15:0] shreg;
    logic        pending;

    logic tick;
    logic rise_ev;
    logic fall_ev;

    // A rise or fall event is the clk in which sck is about to toggle.
    // The current level of sck tells which way the toggle goes.
    assign tick    = (div_cnt == DIV_LAST);
    assign rise_ev = tick && !sck;
    assign fall_ev = tick &&  sck;

    assign fsm_state = state;

    // Free-running SCK divider. It never stops, so the sensor always sees
    // clock edges between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
            sck     <= 1'b1;
        end else if (tick) begin
            div_cnt <= 8'd0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cs        <= 1'b1;
            bitcnt    <= 5'd0;
            shreg     <= 16'd0;
            pending   <= 1'b0;
            value     <= 8'd0;
            frame_err <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= 1'b0;

            // Capture a request that arrives while busy. Writing 1 again while
            // the flag is already set has no effect, so extra requests are dropped.
            if (busy && start) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    // A start in this cycle and a stored pending request
                    // together still start only one conversion.
                    if (start || pending) begin
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_ARM;
                    end
                end

                S_ARM: begin
                    // cs falls on a rise event. The sensor then drives bit 15
                    // on the next fall, and the rise after that samples it.
                    if (rise_ev) begin
                        cs     <= 1'b0;
                        bitcnt <= 5'd0;
                        state  <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (rise_ev) begin
                        shreg  <= {shreg[14:0], sdo};
                        bitcnt <= bitcnt + 5'd1;
                        if (bitcnt == 5'd15) begin
                            cs    <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    value     <= shreg[11:4];
                    frame_err <= |{shreg[15:12], shreg[3:0]};
                    valid     <= 1'b1;
                    state     <= S_GAP;
                end

                S_GAP: begin
                    // One falling edge with cs high lets the sensor reload its
                    // shift buffer before the next frame.
                    if (fall_ev) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    cs    <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmod_als_spi_receiver.sv
// -----------------------------------------------------------------------------
// tb_pmod_als_spi_receiver
//
// Self-checking bench for pmod_als_spi_receiver.
//
// The main instance uses DIV=4 and is connected to a behavioural sensor
// model. The model loads a 16-bit frame when cs falls and shifts it out MSB
// first on SCK falling edges.
//
// Two more instances, with DIV=2 and DIV=7, have sdo tied high. They are
// used to check the SCK period and the start-to-valid latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pmod_als_spi_receiver;

    localparam int DIV = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT signals ----------------
    logic       start;
    logic       sdo;
    logic       cs;
    logic       sck;
    logic       busy;
    logic [7:0] value;
    logic       valid;
    logic       frame_err;
    logic [2:0] fsm_state;

    logic       start_d [2];
    logic       cs_d    [2];
    logic       sck_d   [2];
    logic       busy_d  [2];
    logic [7:0] val_d   [2];
    logic       valid_d [2];
    logic       ferr_d  [2];
    logic [2:0] st_d    [2];

    pmod_als_spi_receiver #(.DIV(DIV)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sdo(sdo),
        .cs(cs), .sck(sck), .busy(busy), .value(value), .valid(valid),
        .frame_err(frame_err), .fsm_state(fsm_state)
    );

    pmod_als_spi_receiver #(.DIV(2)) u_div2 (
        .clk(clk), .rst_n(rst_n), .start(start_d[0]), .sdo(1'b1),
        .cs(cs_d[0]), .sck(sck_d[0]), .busy(busy_d[0]), .value(val_d[0]),
        .valid(valid_d[0]), .frame_err(ferr_d[0]), .fsm_state(st_d[0])
    );

    pmod_als_spi_receiver #(.DIV(7)) u_div7 (
        .clk(clk), .rst_n(rst_n), .start(start_d[1]), .sdo(1'b1),
        .cs(cs_d[1]), .sck(sck_d[1]), .busy(busy_d[1]), .value(val_d[1]),
        .valid(valid_d[1]), .frame_err(ferr_d[1]), .fsm_state(st_d[1])
    );

    // ---------------- scoreboard state ----------------
    logic [8:0]  exp_q   [$];   // {frame_err, value}
    logic [15:0] frame_q [$];   // frames the sensor model sends, in order
    int n_checks  = 0;
    int n_errors  = 0;
    int valid_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- sensor model + output monitor ----------------
    int          tie_mode;      // 0: model, 1: sdo tied 1, 2: sdo tied 0
    logic        sdo_model;
    logic [15:0] cur_frame;
    logic [8:0]  exp_e;
    int          idx;
    int          rise_cnt;
    int          gap_falls;
    logic        seen_frame;
    logic        prev_cs;
    logic        prev_sck;

    assign sdo = (tie_mode == 1) ? 1'b1 : (tie_mode == 2) ? 1'b0 : sdo_model;

    always @(negedge clk) begin
        if (!rst_n) begin
            idx        = 0;
            rise_cnt   = 0;
            gap_falls  = 0;
            seen_frame = 1'b0;
            sdo_model  = 1'b0;
        end else begin
            if (prev_cs && !cs) begin
                cur_frame = 16'h0000;
                if (frame_q.size() > 0) cur_frame = frame_q.pop_front();
                idx      = 0;
                rise_cnt = 0;
                if (seen_frame) check("cs_gap_fall", 32'(gap_falls >= 1), 1);
            end
            if (!prev_sck && sck && !prev_cs) rise_cnt++;
            if (prev_sck && !sck) begin
                if (!cs) begin
                    if (idx < 16) sdo_model = cur_frame[4'(15 - idx)];
                    idx++;
                end else begin
                    gap_falls++;
                end
            end
            if (!prev_cs && cs) begin
                gap_falls  = 0;
                seen_frame = 1'b1;
            end
            if (valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(valid), 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("frame_result", 32'({frame_err, value}), 32'(exp_e));
                    check("rises_cs_low", rise_cnt, 16);
                end
            end
        end
        prev_cs  = cs;
        prev_sck = sck;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] frame);
        frame_q.push_back(frame);
        exp_q.push_back({|{frame[15:12], frame[3:0]}, frame[11:4]});
        pulse_start();
    endtask

    task automatic wait_idle();
        int quiet;
        int n;
        quiet = 0;
        n     = 0;
        while (quiet < 3 && n < 3000) begin
            @(negedge clk);
            n++;
            if (!busy) quiet++;
            else quiet = 0;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic run_div(input int k, input int div);
        int t0;
        int t_r1;
        int t_r2;
        int t_val;
        int n;
        logic prev;
        @(negedge clk);
        start_d[k] = 1'b1;
        @(negedge clk);
        t0 = cyc - 1;
        start_d[k] = 1'b0;
        t_r1 = -1;
        t_r2 = -1;
        t_val = -1;
        n = 0;
        prev = sck_d[k];
        while ((t_val < 0 || t_r2 < 0) && n < 2000) begin
            @(negedge clk);
            n++;
            if (!prev && sck_d[k]) begin
                if (t_r1 < 0) t_r1 = cyc;
                else if (t_r2 < 0) t_r2 = cyc;
            end
            prev = sck_d[k];
            if (valid_d[k] && t_val < 0) t_val = cyc;
        end
        check("div_period", t_r2 - t_r1, 2 * div);
        check("div_latency", 32'(t_val >= 0 && (t_val - t0) <= 34 * div + 2), 1);
        check("div_result", 32'({ferr_d[k], val_d[k]}), 32'h1FF);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t_main;
        int t2;
        int t7;
        int v0;
        int n;
        logic [3:0] hi;
        logic [3:0] lo;
        logic [7:0] val;

        start      = 1'b0;
        start_d[0] = 1'b0;
        start_d[1] = 1'b0;
        tie_mode   = 0;
        sdo_model  = 1'b0;
        prev_cs    = 1'b1;
        prev_sck   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs), 1);
        check("rst_sck", 32'(sck), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_value", 32'(value), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_state", 32'(fsm_state), 0);

        // The first sck toggle comes exactly DIV clk after reset is released
        rst_n  = 1'b1;
        t_main = -1;
        t2     = -1;
        t7     = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (t_main < 0 && !sck) t_main = c;
            if (t2 < 0 && !sck_d[0]) t2 = c;
            if (t7 < 0 && !sck_d[1]) t7 = c;
        end
        check("first_toggle_div4", t_main, 4);
        check("first_toggle_div2", t2, 2);
        check("first_toggle_div7", t7, 7);

        // Basic frame with value 0xAB
        send(16'h0AB0);
        wait_idle();

        // Back-to-back frames: the second start arrives while busy
        send(16'h0000);
        send(16'h0FF0);
        wait_idle();

        // Three starts during a busy frame: exactly two conversions
        v0 = valid_cnt;
        send(16'h05A0);
        repeat (10) @(negedge clk);
        send(16'h0C30);
        repeat (10) @(negedge clk);
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        wait_idle();
        check("two_valids", valid_cnt - v0, 2);

        // sdo tied high, then tied low
        tie_mode = 1;
        exp_q.push_back(9'h1FF);
        pulse_start();
        wait_idle();
        tie_mode = 2;
        exp_q.push_back(9'h000);
        pulse_start();
        wait_idle();
        tie_mode = 0;

        // Random frames, some with nonzero bits outside the value field
        for (int i = 0; i < 6; i++) begin
            hi  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            lo  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            val = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 9)) @(negedge clk);
            send({hi, val, lo});
            wait_idle();
        end

        // Reset in the middle of a frame, around bit 7
        frame_q.push_back(16'h0AB0);
        pulse_start();
        n = 0;
        while (rise_cnt < 8 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reach_bit7", 32'(rise_cnt >= 8), 1);
        v0 = valid_cnt;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_cs", 32'(cs), 1);
            check("abort_sck", 32'(sck), 1);
            check("abort_valid", 32'(valid), 0);
            check("abort_busy", 32'(busy), 0);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_valid", valid_cnt - v0, 0);
        check("abort_value_cleared", 32'(value), 0);
        send(16'h0AB0);
        wait_idle();

        // SCK period and latency for other divider settings
        run_div(0, 2);
        run_div(1, 7);

        check("exp_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
